// File: rtl/sram_access_unit.sv
// Memory-side responder for the main control unit: owns the source/result pixel
// pointers and runs single-word read/write cycles on an asynchronous SRAM bus.
//
// state   | meaning
// IDLE    | bus released, waiting for a new or pending request (read first)
// RD_ACC  | ce_n/oe_n low for WAIT_ST cycles at the captured read address
// RD_CAP  | strobes released, read word captured into o_rdata
// WR_SET  | ce_n low, address/data set up ahead of the write strobe
// WR_STB  | ce_n/we_n low for WAIT_ST cycles
// WR_HOLD | we_n released, ce_n/address/data held for write hold time
module sram_access_unit #(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] RD_BASE = 'h0000,
    parameter logic [ADDR_W-1:0] WR_BASE = 'h8000,
    parameter int                NUM_PIX = 4096,
    parameter int                WAIT_ST = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_frame_start,
    input  logic              i_inc_raddr,
    input  logic              i_inc_waddr,
    input  logic              i_re,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_raddr_ready,
    output logic              o_waddr_ready,
    output logic              o_read_complete,
    output logic              o_write_complete,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [ADDR_W-1:0] RD_LAST  = RD_BASE + ADDR_W'(NUM_PIX - 1);
    localparam logic [ADDR_W-1:0] WR_LAST  = WR_BASE + ADDR_W'(NUM_PIX - 1);
    localparam int                CNT_W    = (WAIT_ST > 1) ? $clog2(WAIT_ST) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_ST - 1);

    typedef enum logic [2:0] {
        IDLE, RD_ACC, RD_CAP, WR_SET, WR_STB, WR_HOLD
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic              rd_started, wr_started;
    logic              upd_r, upd_w;
    logic              rd_pend, wr_pend;
    logic [DATA_W-1:0] wr_data_q;
    logic              rd_req, wr_req, rd_take, wr_take;

    assign o_raddr_ready = !i_inc_raddr && !upd_r;
    assign o_waddr_ready = !i_inc_waddr && !upd_w;

    // The first increment after a restart only arms the pointer, so the first
    // pixel is addressed at the base.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr     <= RD_BASE;
            wr_ptr     <= WR_BASE;
            rd_started <= 1'b0;
            wr_started <= 1'b0;
            upd_r      <= 1'b0;
            upd_w      <= 1'b0;
        end else begin
            upd_r <= i_inc_raddr;
            upd_w <= i_inc_waddr;
            if (i_frame_start) begin
                rd_ptr     <= RD_BASE;
                wr_ptr     <= WR_BASE;
                rd_started <= 1'b0;
                wr_started <= 1'b0;
            end else begin
                if (i_inc_raddr) begin
                    if (!rd_started)       rd_started <= 1'b1;
                    else if (rd_ptr == RD_LAST) rd_ptr <= RD_BASE;
                    else                   rd_ptr <= rd_ptr + ADDR_W'(1);
                end
                if (i_inc_waddr) begin
                    if (!wr_started)       wr_started <= 1'b1;
                    else if (wr_ptr == WR_LAST) wr_ptr <= WR_BASE;
                    else                   wr_ptr <= wr_ptr + ADDR_W'(1);
                end
            end
        end
    end

    assign rd_req  = i_re || rd_pend;
    assign wr_req  = i_we || wr_pend;
    assign rd_take = (state == IDLE) && rd_req;
    assign wr_take = (state == IDLE) && !rd_req && wr_req;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (rd_req)      state_n = RD_ACC;
                else if (wr_req) state_n = WR_SET;
            end
            RD_ACC:  if (cnt == '0) state_n = RD_CAP;
            RD_CAP:  state_n = IDLE;
            WR_SET:  state_n = WR_STB;
            WR_STB:  if (cnt == '0) state_n = WR_HOLD;
            WR_HOLD: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes are registered from the next state so the SRAM sees glitch-free
    // edges aligned with the state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= IDLE;
            cnt              <= '0;
            rd_pend          <= 1'b0;
            wr_pend          <= 1'b0;
            wr_data_q        <= '0;
            sram_addr        <= '0;
            sram_wdata       <= '0;
            o_rdata          <= '0;
            o_read_complete  <= 1'b0;
            o_write_complete <= 1'b0;
            o_done           <= 1'b0;
            sram_ce_n        <= 1'b1;
            sram_oe_n        <= 1'b1;
            sram_we_n        <= 1'b1;
        end else begin
            state <= state_n;

            if ((state != RD_ACC && state_n == RD_ACC) ||
                (state != WR_STB && state_n == WR_STB))
                cnt <= CNT_LOAD;
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);

            if (rd_take)   rd_pend <= 1'b0;
            else if (i_re) rd_pend <= 1'b1;

            // A write request arriving while one is already pending is dropped,
            // keeping the data of the first.
            if (wr_take) begin
                wr_pend <= 1'b0;
            end else if (i_we && !wr_pend) begin
                wr_pend   <= 1'b1;
                wr_data_q <= i_wdata;
            end

            if (rd_take) sram_addr <= rd_ptr;
            if (wr_take) begin
                sram_addr  <= wr_ptr;
                sram_wdata <= wr_pend ? wr_data_q : i_wdata;
            end

            if (state == RD_CAP) o_rdata <= sram_rdata;
            o_read_complete  <= (state == RD_CAP);
            o_write_complete <= (state == WR_HOLD);

            if (i_frame_start)
                o_done <= 1'b0;
            else if (state == WR_HOLD && sram_addr == WR_LAST)
                o_done <= 1'b1;

            sram_ce_n <= (state_n == IDLE) || (state_n == RD_CAP);
            sram_oe_n <= (state_n != RD_ACC);
            sram_we_n <= (state_n != WR_STB);
        end
    end

endmodule

// File: tb/tb_sram_access_unit.sv
// Bench for sram_access_unit: vector tables, hand-written corner sequences and a
// randomized run against a pixel-count based pointer/done model.
module tb_sram_access_unit;

    localparam int          ADDR_W  = 16;
    localparam int          DATA_W  = 32;
    localparam int          NUM_PIX = 4;
    localparam int          WAIT_ST = 2;
    localparam logic [15:0] RD_BASE = 16'h0000;
    localparam logic [15:0] WR_BASE = 16'h8000;

    logic              clk, n_rst;
    logic              i_frame_start, i_inc_raddr, i_inc_waddr, i_re, i_we;
    logic [DATA_W-1:0] i_wdata;
    logic              o_raddr_ready, o_waddr_ready, o_read_complete, o_write_complete;
    logic [DATA_W-1:0] o_rdata;
    logic              o_done;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata, sram_rdata;
    logic              sram_ce_n, sram_oe_n, sram_we_n;

    sram_access_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_BASE(RD_BASE), .WR_BASE(WR_BASE),
        .NUM_PIX(NUM_PIX), .WAIT_ST(WAIT_ST)
    ) dut (
        .clk(clk), .n_rst(n_rst), .i_frame_start(i_frame_start),
        .i_inc_raddr(i_inc_raddr), .i_inc_waddr(i_inc_waddr), .i_re(i_re), .i_we(i_we),
        .i_wdata(i_wdata), .o_raddr_ready(o_raddr_ready), .o_waddr_ready(o_waddr_ready),
        .o_read_complete(o_read_complete), .o_write_complete(o_write_complete),
        .o_rdata(o_rdata), .o_done(o_done), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: source region is a fixed pattern ROM, writes land in wr_mem.
    function automatic logic [31:0] pat(input logic [15:0] a);
        return {a ^ 16'hC35A, ~a};
    endfunction
    assign sram_rdata = pat(sram_addr);

    bit [31:0] wr_mem [0:65535];
    always @(posedge clk) if (!sram_ce_n && !sram_we_n) wr_mem[sram_addr] <= sram_wdata;

    int n_cmp = 0, n_bad = 0;
    int rd_n = 0, wr_n = 0;
    bit exp_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_rd();
        return RD_BASE + 16'((rd_n == 0) ? 0 : (rd_n - 1) % NUM_PIX);
    endfunction
    function automatic logic [15:0] exp_wr();
        return WR_BASE + 16'((wr_n == 0) ? 0 : (wr_n - 1) % NUM_PIX);
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_inc(input bit r, input bit w);
        i_inc_raddr = r; i_inc_waddr = w;
        step();
        i_inc_raddr = 0; i_inc_waddr = 0;
        if (r) rd_n++;
        if (w) wr_n++;
    endtask

    task automatic frame_start();
        i_frame_start = 1;
        step();
        i_frame_start = 0;
        rd_n = 0; wr_n = 0; exp_done = 0;
    endtask

    int ob_rc_n, ob_rc_lat, ob_wc_n, ob_wc_lat, ob_oe_cnt, ob_we_cnt, ob_overlap, ob_addr_chg;
    logic [15:0] ob_rd_addr, ob_wr_addr, ob_prev_addr;
    logic [31:0] ob_rdata, ob_wdata;
    bit ob_prev_ce;

    // k = 0 is the cycle in which the request is driven.
    task automatic observe(input int ncyc);
        ob_rc_n = 0; ob_rc_lat = -1; ob_wc_n = 0; ob_wc_lat = -1;
        ob_oe_cnt = 0; ob_we_cnt = 0; ob_overlap = 0; ob_addr_chg = 0;
        ob_rd_addr = '1; ob_wr_addr = '1; ob_rdata = '0; ob_wdata = '0;
        ob_prev_ce = 0; ob_prev_addr = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (!sram_oe_n) begin ob_oe_cnt++; ob_rd_addr = sram_addr; end
            if (!sram_we_n) begin ob_we_cnt++; ob_wr_addr = sram_addr; ob_wdata = sram_wdata; end
            if (!sram_oe_n && !sram_we_n) ob_overlap++;
            if (!sram_ce_n && ob_prev_ce && sram_addr != ob_prev_addr) ob_addr_chg++;
            ob_prev_ce = !sram_ce_n;
            ob_prev_addr = sram_addr;
            if (o_read_complete) begin
                if (ob_rc_n == 0) ob_rc_lat = k;
                ob_rc_n++;
                ob_rdata = o_rdata;
            end
            if (o_write_complete) begin
                if (ob_wc_n == 0) ob_wc_lat = k;
                ob_wc_n++;
            end
        end
    endtask

    task automatic access(input bit r, input bit w, input logic [31:0] d,
                          input logic [15:0] ra, input logic [15:0] wa);
        fork
            observe(16);
            begin
                i_re = r; i_we = w; i_wdata = d;
                step();
                i_re = 0; i_we = 0; i_wdata = $urandom;
            end
        join
        step();
        chk("read_count", ob_rc_n, r ? 1 : 0);
        chk("write_count", ob_wc_n, w ? 1 : 0);
        if (r) begin
            chk("read_latency", ob_rc_lat, WAIT_ST + 2);
            chk("oe_low_cycles", ob_oe_cnt, WAIT_ST);
            chk("read_addr", ob_rd_addr, ra);
            chk("rdata", ob_rdata, pat(ra));
        end
        if (w) begin
            // A simultaneous read is served first; the write starts from the
            // IDLE cycle after the read completes.
            chk("write_latency", ob_wc_lat, r ? (WAIT_ST + 2) + (WAIT_ST + 3) : WAIT_ST + 3);
            chk("we_low_cycles", ob_we_cnt, WAIT_ST);
            chk("write_addr", ob_wr_addr, wa);
            chk("write_data_bus", ob_wdata, d);
            chk("write_mem", wr_mem[wa], d);
            if (wa == WR_BASE + 16'(NUM_PIX - 1)) exp_done = 1;
        end
        chk("strobe_overlap", ob_overlap, 0);
        chk("addr_stable", ob_addr_chg, 0);
        chk("done", o_done, exp_done);
    endtask

    typedef struct { bit inc_r; bit inc_w; bit rr; bit wr; } rdy_vec_t;
    typedef struct { bit fs; int n_inc; logic [15:0] addr; } rd_vec_t;
    rdy_vec_t rv [10];
    rd_vec_t  tv [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rv[0] = '{1, 0, 0, 1}; rv[1] = '{0, 0, 0, 1}; rv[2] = '{0, 0, 1, 1};
        rv[3] = '{0, 1, 1, 0}; rv[4] = '{0, 0, 1, 0}; rv[5] = '{0, 0, 1, 1};
        rv[6] = '{1, 1, 0, 0}; rv[7] = '{1, 0, 0, 0}; rv[8] = '{0, 0, 0, 1};
        rv[9] = '{0, 0, 1, 1};
        tv[0] = '{1, 3, 16'h0002}; tv[1] = '{0, 1, 16'h0003}; tv[2] = '{0, 1, 16'h0000};
        tv[3] = '{1, 0, 16'h0000}; tv[4] = '{1, 1, 16'h0000}; tv[5] = '{1, 5, 16'h0000};
        tv[6] = '{0, 2, 16'h0002};

        n_rst = 0; i_frame_start = 0; i_inc_raddr = 0; i_inc_waddr = 0;
        i_re = 0; i_we = 0; i_wdata = '0;
        #12;
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_addr", sram_addr, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_done", o_done, 0);
        chk("rst_completes", {o_read_complete, o_write_complete}, 0);
        chk("rst_ready", {o_raddr_ready, o_waddr_ready}, 2'b11);
        n_rst = 1;
        step();

        foreach (rv[i]) begin
            i_inc_raddr = rv[i].inc_r; i_inc_waddr = rv[i].inc_w;
            @(negedge clk);
            chk($sformatf("raddr_ready[%0d]", i), o_raddr_ready, rv[i].rr);
            chk($sformatf("waddr_ready[%0d]", i), o_waddr_ready, rv[i].wr);
            step();
        end
        i_inc_raddr = 0; i_inc_waddr = 0;

        foreach (tv[i]) begin
            if (tv[i].fs) frame_start();
            for (int j = 0; j < tv[i].n_inc; j++) pulse_inc(1, 0);
            access(1, 0, 32'h0, tv[i].addr, 16'h0);
        end

        frame_start();
        pulse_inc(0, 1);
        access(0, 1, 32'hA5A5_0F0F, 16'h0, WR_BASE);

        frame_start();
        pulse_inc(1, 1);
        access(1, 1, 32'h1234_5678, RD_BASE, WR_BASE);

        frame_start();
        for (int p = 0; p < NUM_PIX; p++) begin
            pulse_inc(0, 1);
            access(0, 1, 32'hD000_0000 + 32'(p), 16'h0, WR_BASE + 16'(p));
        end
        chk("done_after_last", o_done, 1);
        frame_start();
        chk("done_cleared", o_done, 0);

        // Read requested twice during a write: one read, after WR_HOLD.
        frame_start();
        pulse_inc(0, 1);
        fork
            observe(20);
            begin
                i_we = 1; i_wdata = 32'hCAFE_F00D;
                step();
                i_we = 0;
                step();
                i_re = 1;
                step();
                step();
                i_re = 0;
            end
        join
        step();
        chk("rdw_write_count", ob_wc_n, 1);
        chk("rdw_write_latency", ob_wc_lat, WAIT_ST + 3);
        chk("rdw_read_count", ob_rc_n, 1);
        chk("rdw_read_latency", ob_rc_lat, (WAIT_ST + 3) + 1 + (WAIT_ST + 2) - 1);
        chk("rdw_read_addr", ob_rd_addr, RD_BASE);
        chk("rdw_overlap", ob_overlap, 0);

        // Reset in the middle of a read strobe.
        pulse_inc(1, 1); pulse_inc(1, 1); pulse_inc(1, 1);
        i_re = 1;
        step();
        i_re = 0;
        #2;
        chk("mid_rd_oe_low", sram_oe_n, 0);
        n_rst = 0;
        #1;
        chk("async_ce_n", sram_ce_n, 1);
        chk("async_oe_n", sram_oe_n, 1);
        fork
            observe(10);
            begin
                @(negedge clk); @(negedge clk); #1;
                n_rst = 1;
            end
        join
        step();
        rd_n = 0; wr_n = 0; exp_done = 0;
        chk("rst_no_complete", ob_rc_n, 0);
        pulse_inc(0, 1);
        access(1, 1, 32'h0BAD_BEEF, RD_BASE, WR_BASE);

        for (int it = 0; it < 40; it++) begin
            int nr, nw, op;
            if ($urandom_range(0, 7) == 0) frame_start();
            nr = $urandom_range(0, 3);
            nw = $urandom_range(0, 2);
            for (int j = 0; j < ((nr > nw) ? nr : nw); j++) begin
                pulse_inc(j < nr, j < nw);
                if ($urandom_range(0, 1) == 1) step();
            end
            op = $urandom_range(0, 2);
            access(op != 1, op != 0, $urandom, exp_rd(), exp_wr());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
